// File: rtl/cart_sdram_port.sv
// Bridge between the cartridge mapper's level-style memory port and the shared SDRAM
// controller's req/ack protocol, with a one-entry read cache and a one-deep posted write.
module cart_sdram_port #(
  parameter int ADDR_W  = 25,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] ram_addr,
  input  logic [7:0]        ram_din,
  input  logic              ram_we,
  input  logic              ram_rd,
  input  logic              flush,
  output logic [7:0]        ram_dout,
  output logic              ram_ready,
  output logic              sd_req,
  output logic              sd_we,
  output logic [ADDR_W-1:0] sd_addr,
  output logic [7:0]        sd_din,
  input  logic [7:0]        sd_dout,
  input  logic              sd_ack,
  output logic              err
);

  typedef enum logic [1:0] {IDLE, WRITE, READ} state_t;

  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

  state_t              state_q, state_d;
  logic                buf_full_q, buf_full_d;
  logic [ADDR_W-1:0]   buf_addr_q, buf_addr_d;
  logic [7:0]          buf_data_q, buf_data_d;
  logic                cache_valid_q, cache_valid_d;
  logic [ADDR_W-1:0]   cache_addr_q, cache_addr_d;
  logic [7:0]          dout_q, dout_d;
  logic                sd_req_q, sd_req_d;
  logic                sd_we_q, sd_we_d;
  logic [ADDR_W-1:0]   sd_addr_q, sd_addr_d;
  logic [7:0]          sd_din_q, sd_din_d;
  logic                err_q, err_d;
  logic                flush_seen_q, flush_seen_d;
  logic [7:0]          wd_cnt_q, wd_cnt_d;
  logic                cache_hit;
  logic                wd_expire;

  assign cache_hit = cache_valid_q && (cache_addr_q == ram_addr);
  assign wd_expire = (wd_cnt_q + 8'd1) == TIMEOUT_C;

  always_comb begin
    state_d       = state_q;
    buf_full_d    = buf_full_q;
    buf_addr_d    = buf_addr_q;
    buf_data_d    = buf_data_q;
    cache_valid_d = cache_valid_q;
    cache_addr_d  = cache_addr_q;
    dout_d        = dout_q;
    sd_req_d      = sd_req_q;
    sd_we_d       = sd_we_q;
    sd_addr_d     = sd_addr_q;
    sd_din_d      = sd_din_q;
    err_d         = err_q;
    flush_seen_d  = flush_seen_q;
    wd_cnt_d      = wd_cnt_q;

    // A write arriving while the buffer is occupied is lost; ram_ready guards against it.
    if (ram_we && !buf_full_q) begin
      buf_full_d = 1'b1;
      buf_addr_d = ram_addr;
      buf_data_d = ram_din;
    end

    case (state_q)
      IDLE: begin
        if (buf_full_q) begin
          sd_addr_d  = buf_addr_q;
          sd_din_d   = buf_data_q;
          sd_we_d    = 1'b1;
          sd_req_d   = 1'b1;
          wd_cnt_d   = 8'd0;
          buf_full_d = 1'b0;
          state_d    = WRITE;
        end else if (ram_rd && !cache_hit && !ram_we) begin
          // A write captured this cycle is drained before the read miss is served.
          sd_addr_d    = ram_addr;
          sd_we_d      = 1'b0;
          sd_req_d     = 1'b1;
          wd_cnt_d     = 8'd0;
          flush_seen_d = 1'b0;
          state_d      = READ;
        end
      end
      WRITE: begin
        if (sd_ack) begin
          sd_req_d = 1'b0;
          state_d  = IDLE;
          if (cache_valid_q && (cache_addr_q == sd_addr_q)) begin
            dout_d = sd_din_q;
          end
        end else if (wd_expire) begin
          sd_req_d = 1'b0;
          err_d    = 1'b1;
          state_d  = IDLE;
        end else begin
          wd_cnt_d = wd_cnt_q + 8'd1;
        end
      end
      READ: begin
        if (flush) begin
          flush_seen_d = 1'b1;
        end
        if (sd_ack) begin
          sd_req_d      = 1'b0;
          cache_addr_d  = sd_addr_q;
          dout_d        = sd_dout;
          cache_valid_d = !(flush_seen_q || flush);
          state_d       = IDLE;
        end else if (wd_expire) begin
          // Mark the dead address as cached so a held ram_rd does not hammer the controller.
          sd_req_d      = 1'b0;
          err_d         = 1'b1;
          dout_d        = 8'hFF;
          cache_addr_d  = sd_addr_q;
          cache_valid_d = 1'b1;
          state_d       = IDLE;
        end else begin
          wd_cnt_d = wd_cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (flush) begin
      cache_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      buf_full_q    <= 1'b0;
      buf_addr_q    <= '0;
      buf_data_q    <= 8'h00;
      cache_valid_q <= 1'b0;
      cache_addr_q  <= '0;
      dout_q        <= 8'hFF;
      sd_req_q      <= 1'b0;
      sd_we_q       <= 1'b0;
      sd_addr_q     <= '0;
      sd_din_q      <= 8'h00;
      err_q         <= 1'b0;
      flush_seen_q  <= 1'b0;
      wd_cnt_q      <= 8'd0;
    end else begin
      state_q       <= state_d;
      buf_full_q    <= buf_full_d;
      buf_addr_q    <= buf_addr_d;
      buf_data_q    <= buf_data_d;
      cache_valid_q <= cache_valid_d;
      cache_addr_q  <= cache_addr_d;
      dout_q        <= dout_d;
      sd_req_q      <= sd_req_d;
      sd_we_q       <= sd_we_d;
      sd_addr_q     <= sd_addr_d;
      sd_din_q      <= sd_din_d;
      err_q         <= err_d;
      flush_seen_q  <= flush_seen_d;
      wd_cnt_q      <= wd_cnt_d;
    end
  end

  assign ram_ready = !buf_full_q && (state_q != WRITE) &&
                     (!ram_rd || (cache_hit && (state_q == IDLE)));
  assign ram_dout  = dout_q;
  assign sd_req    = sd_req_q;
  assign sd_we     = sd_we_q;
  assign sd_addr   = sd_addr_q;
  assign sd_din    = sd_din_q;
  assign err       = err_q;

endmodule

// File: tb/tb_cart_sdram_port.sv
// Bench for cart_sdram_port: an SDRAM controller responder plus directed scenarios and a
// randomized read/write/flush run checked against a memory-and-cache model.
module tb_cart_sdram_port;

  logic        clk;
  logic        reset_n;
  logic [24:0] ram_addr;
  logic [7:0]  ram_din;
  logic        ram_we;
  logic        ram_rd;
  logic        flush;
  logic [7:0]  ram_dout;
  logic        ram_ready;
  logic        sd_req;
  logic        sd_we;
  logic [24:0] sd_addr;
  logic [7:0]  sd_din;
  logic [7:0]  sd_dout;
  logic        sd_ack;
  logic        err;

  int errors = 0;
  int checks = 0;

  // Responder controls, written only by the main process.
  int ack_delay = 3;
  bit resp_en   = 1'b1;
  int stale_req = 0;

  // Controller-side transaction log, written only by the responder.
  logic        log_we[$];
  logic [24:0] log_addr[$];
  logic [7:0]  log_din[$];

  cart_sdram_port #(.ADDR_W(25), .TIMEOUT(8)) dut (
    .clk(clk), .reset_n(reset_n), .ram_addr(ram_addr), .ram_din(ram_din),
    .ram_we(ram_we), .ram_rd(ram_rd), .flush(flush), .ram_dout(ram_dout),
    .ram_ready(ram_ready), .sd_req(sd_req), .sd_we(sd_we), .sd_addr(sd_addr),
    .sd_din(sd_din), .sd_dout(sd_dout), .sd_ack(sd_ack), .err(err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [7:0] dflt(input logic [24:0] a);
    return a[7:0] ^ 8'h5C;
  endfunction

  // SDRAM controller model: acks ack_delay cycles after seeing a request.
  initial begin
    logic [7:0] sdmem [logic [24:0]];
    int wait_cnt;
    int stale_done;
    wait_cnt   = 0;
    stale_done = 0;
    sd_ack     = 1'b0;
    sd_dout    = 8'h00;
    sdmem[25'h100] = 8'h5A;
    sdmem[25'h200] = 8'h11;
    sdmem[25'h300] = 8'h3C;
    forever begin
      @(posedge clk);
      #1;
      if (sd_ack) begin
        sd_ack = 1'b0;
      end else if (stale_req != stale_done) begin
        stale_done++;
        sd_ack  = 1'b1;
        sd_dout = 8'h99;
      end else if (sd_req && resp_en) begin
        wait_cnt++;
        if (wait_cnt >= ack_delay) begin
          wait_cnt = 0;
          sd_ack   = 1'b1;
          log_we.push_back(sd_we);
          log_addr.push_back(sd_addr);
          log_din.push_back(sd_din);
          if (sd_we) sdmem[sd_addr] = sd_din;
          else       sd_dout = sdmem.exists(sd_addr) ? sdmem[sd_addr] : dflt(sd_addr);
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_ready(input int budget, output bit ok);
    ok = 1'b0;
    #1;
    for (int i = 0; i < budget; i++) begin
      if (ram_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    tick();
    tick();
    checks++; if (sd_req !== 1'b0) begin errors++; $display("FAIL reset_sd_req: got %b expected 0", sd_req); end
    checks++; if (sd_we !== 1'b0) begin errors++; $display("FAIL reset_sd_we: got %b expected 0", sd_we); end
    checks++; if (sd_addr !== 25'h0) begin errors++; $display("FAIL reset_sd_addr: got %h expected 0", sd_addr); end
    checks++; if (sd_din !== 8'h00) begin errors++; $display("FAIL reset_sd_din: got %h expected 00", sd_din); end
    checks++; if (ram_dout !== 8'hFF) begin errors++; $display("FAIL reset_ram_dout: got %h expected ff", ram_dout); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", err); end
    checks++; if (ram_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", ram_ready); end
    reset_n = 1'b1;
    tick();
    $display("test_reset done");
  endtask

  task automatic test_read_miss();
    ack_delay = 3;
    ram_addr  = 25'h100;
    ram_rd    = 1'b1;
    tick();
    checks++; if (sd_req !== 1'b1 || sd_we !== 1'b0 || sd_addr !== 25'h100) begin
      errors++; $display("FAIL miss_req: got req=%b we=%b addr=%h expected 1 0 00100", sd_req, sd_we, sd_addr);
    end
    tick();
    tick();
    checks++; if (ram_ready !== 1'b0) begin errors++; $display("FAIL miss_ready_early: got %b expected 0", ram_ready); end
    tick();
    checks++; if (ram_ready !== 1'b1 || ram_dout !== 8'h5A) begin
      errors++; $display("FAIL miss_data: got ready=%b dout=%h expected 1 5a", ram_ready, ram_dout);
    end
    for (int i = 0; i < 20; i++) tick();
    checks++; if (log_we.size() != 1 || ram_ready !== 1'b1 || sd_req !== 1'b0) begin
      errors++; $display("FAIL miss_hold: got requests=%0d ready=%b req=%b expected 1 1 0", log_we.size(), ram_ready, sd_req);
    end
    $display("test_read_miss done: requests=%0d", log_we.size());
  endtask

  task automatic test_write_stream();
    int base;
    bit ok;
    ack_delay = 4;
    ram_rd    = 1'b0;
    base      = log_we.size();
    for (int i = 0; i < 16; i++) begin
      wait_ready(40, ok);
      checks++; if (!ok) begin errors++; $display("FAIL wstream_ready: byte %0d got ready=0 expected 1", i); end
      ram_addr = 25'(i);
      ram_din  = 8'(8'hA0 + i);
      ram_we   = 1'b1;
      tick();
      ram_we   = 1'b0;
    end
    wait_ready(40, ok);
    checks++; if (log_we.size() != base + 16) begin
      errors++; $display("FAIL wstream_count: got %0d expected 16", log_we.size() - base);
    end else begin
      for (int i = 0; i < 16; i++) begin
        checks++;
        if (log_we[base+i] !== 1'b1 || log_addr[base+i] !== 25'(i) || log_din[base+i] !== 8'(8'hA0 + i)) begin
          errors++; $display("FAIL wstream_entry%0d: got we=%b addr=%h din=%h expected 1 %h %h",
                             i, log_we[base+i], log_addr[base+i], log_din[base+i], 25'(i), 8'(8'hA0 + i));
        end
      end
    end
    $display("test_write_stream done: writes=%0d", log_we.size() - base);
  endtask

  task automatic test_coherency();
    int base;
    bit ok;
    ack_delay = 2;
    ram_addr  = 25'h200;
    ram_rd    = 1'b1;
    wait_ready(30, ok);
    checks++; if (!ok || ram_dout !== 8'h11) begin
      errors++; $display("FAIL coh_first_read: got ok=%b dout=%h expected 1 11", ok, ram_dout);
    end
    ram_rd  = 1'b0;
    base    = log_we.size();
    ram_din = 8'h77;
    ram_we  = 1'b1;
    tick();
    ram_we  = 1'b0;
    wait_ready(30, ok);
    ram_rd  = 1'b1;
    #1;
    checks++; if (ram_ready !== 1'b1 || ram_dout !== 8'h77) begin
      errors++; $display("FAIL coh_hit: got ready=%b dout=%h expected 1 77", ram_ready, ram_dout);
    end
    for (int i = 0; i < 5; i++) tick();
    checks++; if (log_we.size() != base + 1 || log_we[base] !== 1'b1) begin
      errors++; $display("FAIL coh_accesses: got %0d new accesses expected exactly 1 write", log_we.size() - base);
    end
    $display("test_coherency done");
  endtask

  task automatic test_flush_inflight();
    int base;
    int n;
    bit ok;
    ack_delay = 5;
    base      = log_we.size();
    ram_addr  = 25'h300;
    ram_rd    = 1'b1;
    tick();
    checks++; if (sd_req !== 1'b1 || sd_addr !== 25'h300) begin
      errors++; $display("FAIL flush_req1: got req=%b addr=%h expected 1 00300", sd_req, sd_addr);
    end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    n = 0;
    while (log_we.size() < base + 1 && n < 20) begin tick(); n++; end
    tick();
    checks++; if (ram_ready !== 1'b0 || sd_req !== 1'b0) begin
      errors++; $display("FAIL flush_after_ack: got ready=%b req=%b expected 0 0", ram_ready, sd_req);
    end
    tick();
    checks++; if (sd_req !== 1'b1 || sd_addr !== 25'h300 || ram_ready !== 1'b0) begin
      errors++; $display("FAIL flush_reissue: got req=%b addr=%h ready=%b expected 1 00300 0", sd_req, sd_addr, ram_ready);
    end
    wait_ready(30, ok);
    checks++; if (!ok || ram_dout !== 8'h3C) begin
      errors++; $display("FAIL flush_second_data: got ok=%b dout=%h expected 1 3c", ok, ram_dout);
    end
    checks++; if (log_we.size() != base + 2 || log_we[base+1] !== 1'b0 || log_addr[base+1] !== 25'h300) begin
      errors++; $display("FAIL flush_accesses: got %0d accesses expected 2 reads of 00300", log_we.size() - base);
    end
    $display("test_flush_inflight done");
  endtask

  task automatic test_timeout();
    int base;
    int n;
    resp_en  = 1'b0;
    base     = log_we.size();
    ram_addr = 25'h400;
    ram_rd   = 1'b1;
    tick();
    n = 0;
    while (sd_req === 1'b1 && n < 50) begin n++; tick(); end
    checks++; if (n != 8) begin errors++; $display("FAIL timeout_len: got %0d cycles expected 8", n); end
    checks++; if (err !== 1'b1 || ram_dout !== 8'hFF || ram_ready !== 1'b1) begin
      errors++; $display("FAIL timeout_state: got err=%b dout=%h ready=%b expected 1 ff 1", err, ram_dout, ram_ready);
    end
    stale_req++;
    for (int i = 0; i < 4; i++) tick();
    checks++; if (ram_dout !== 8'hFF || sd_req !== 1'b0 || err !== 1'b1 || ram_ready !== 1'b1 || log_we.size() != base) begin
      errors++; $display("FAIL timeout_stale_ack: got dout=%h req=%b err=%b ready=%b expected ff 0 1 1",
                         ram_dout, sd_req, err, ram_ready);
    end
    $display("test_timeout done: cycles=%0d", n);
  endtask

  task automatic test_reset_mid_write();
    int base;
    base     = log_we.size();
    ram_rd   = 1'b0;
    ram_addr = 25'h50;
    ram_din  = 8'h42;
    ram_we   = 1'b1;
    tick();
    ram_we   = 1'b0;
    tick();
    checks++; if (sd_req !== 1'b1 || sd_we !== 1'b1 || sd_addr !== 25'h50 || sd_din !== 8'h42) begin
      errors++; $display("FAIL rstw_write: got req=%b we=%b addr=%h din=%h expected 1 1 00050 42", sd_req, sd_we, sd_addr, sd_din);
    end
    tick();
    reset_n = 1'b0;
    #1;
    checks++; if (sd_req !== 1'b0 || err !== 1'b0 || ram_dout !== 8'hFF || ram_ready !== 1'b1) begin
      errors++; $display("FAIL rstw_async: got req=%b err=%b dout=%h ready=%b expected 0 0 ff 1", sd_req, err, ram_dout, ram_ready);
    end
    tick();
    reset_n = 1'b1;
    stale_req++;
    for (int i = 0; i < 5; i++) tick();
    checks++; if (sd_req !== 1'b0 || ram_dout !== 8'hFF || ram_ready !== 1'b1 || err !== 1'b0 || log_we.size() != base) begin
      errors++; $display("FAIL rstw_after: got req=%b dout=%h ready=%b err=%b expected 0 ff 1 0", sd_req, ram_dout, ram_ready, err);
    end
    resp_en = 1'b1;
    $display("test_reset_mid_write done");
  endtask

  task automatic test_random();
    logic [7:0]  exp_mem [logic [24:0]];
    bit          mc_valid;
    logic [24:0] mc_addr;
    logic [24:0] a;
    logic [7:0]  d;
    logic [7:0]  exp_d;
    int          base;
    int          op;
    bit          ok;
    bit          hit;
    mc_valid = 1'b0;
    mc_addr  = '0;
    for (int t = 0; t < 80; t++) begin
      ack_delay = int'($urandom_range(1, 4));
      op = int'($urandom_range(0, 9));
      a  = 25'h1000 + 25'($urandom_range(0, 7));
      base = log_we.size();
      if (op == 0) begin
        ram_rd = 1'b0;
        flush  = 1'b1;
        tick();
        flush  = 1'b0;
        mc_valid = 1'b0;
        $display("rnd %0d flush", t);
      end else if (op <= 4) begin
        d = 8'($urandom);
        ram_rd = 1'b0;
        wait_ready(60, ok);
        ram_addr = a;
        ram_din  = d;
        ram_we   = 1'b1;
        tick();
        ram_we   = 1'b0;
        wait_ready(60, ok);
        exp_mem[a] = d;
        checks++;
        if (!ok || log_we.size() != base + 1 || log_we[base] !== 1'b1 || log_addr[base] !== a || log_din[base] !== d) begin
          errors++; $display("FAIL rnd_write: op %0d addr=%h data=%h not seen as a single SDRAM write", t, a, d);
        end
        $display("rnd %0d write addr=%h data=%h", t, a, d);
      end else begin
        hit   = mc_valid && (mc_addr == a);
        exp_d = exp_mem.exists(a) ? exp_mem[a] : dflt(a);
        ram_addr = a;
        ram_rd   = 1'b1;
        wait_ready(60, ok);
        checks++;
        if (!ok || ram_dout !== exp_d) begin
          errors++; $display("FAIL rnd_read_data: op %0d addr=%h got ok=%b dout=%h expected %h", t, a, ok, ram_dout, exp_d);
        end
        checks++;
        if (hit && log_we.size() != base) begin
          errors++; $display("FAIL rnd_hit_access: op %0d addr=%h got %0d accesses expected 0", t, a, log_we.size() - base);
        end else if (!hit && (log_we.size() != base + 1 || log_we[base] !== 1'b0 || log_addr[base] !== a)) begin
          errors++; $display("FAIL rnd_miss_access: op %0d addr=%h got %0d accesses expected 1 read", t, a, log_we.size() - base);
        end
        mc_valid = 1'b1;
        mc_addr  = a;
        $display("rnd %0d read addr=%h dout=%h hit=%b", t, a, ram_dout, hit);
      end
    end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL rnd_err: got %b expected 0", err); end
  endtask

  initial begin
    reset_n  = 1'b0;
    ram_addr = '0;
    ram_din  = 8'h00;
    ram_we   = 1'b0;
    ram_rd   = 1'b0;
    flush    = 1'b0;
    test_reset();
    test_read_miss();
    test_write_stream();
    test_coherency();
    test_flush_inflight();
    test_timeout();
    test_reset_mid_write();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish within time limit");
    $fatal(1, "global timeout");
  end

endmodule

// File: doc/cart_sdram_port.md
Name: cart_sdram_port

Overview:
- Downstream of the cartridge ROM/mapper stage.
- Turns its level-style memory interface into a request/acknowledge transaction protocol for the shared SDRAM controller:
  - ram_addr, ram_rd, ram_we and ram_din come in.
  - ram_dout and ram_ready go back.
- Holds a one-entry read cache so a stable CPU fetch address costs one SDRAM access.
- Holds a one-deep posted-write buffer, so ROM image loading stalls only through ram_ready.

Parameters:
- ADDR_W, 25, SDRAM byte address width.
- TIMEOUT, 255, maximum cycles to wait for sd_ack before aborting a transaction (1..255).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- ram_addr  in  ADDR_W  byte address from the mapper stage.
- ram_din  in  8  write data (ROM load byte).
- ram_we  in  1  one-cycle write strobe.
- ram_rd  in  1  read request level; held while the slot is selected.
- flush  in  1  invalidate the read cache (mapper change, new image).
- ram_dout  out  8  read data (cache contents).
- ram_ready  out  1  high when the bridge can accept a write and the read data matches ram_addr.
- sd_req  out  1  SDRAM request; level, held until sd_ack.
- sd_we  out  1  1 = write transaction, 0 = read; stable while sd_req.
- sd_addr  out  ADDR_W  transaction address; stable while sd_req.
- sd_din  out  8  write data; stable while sd_req.
- sd_dout  in  8  read data; valid in the sd_ack cycle.
- sd_ack  in  1  one-cycle transaction completion.
- err  out  1  sticky timeout flag.

Behaviour:
- Reset (reset_n low, async): all registered outputs clear immediately.
  - sd_req=0, sd_we=0, sd_addr=0, sd_din=0, ram_dout=8'hFF, err=0.
  - Cache invalid, write buffer empty, state IDLE, watchdog counter 0.
- FSM states: IDLE, WRITE, READ.
- Write buffer:
  - ram_we high captures {ram_addr, ram_din} into the buffer if it is empty.
  - ram_we while the buffer is full is dropped. This is a protocol violation; upstream must honour ram_ready.
- IDLE, priority order each cycle:
  1. Buffer full -> load sd_addr/sd_din from the buffer, sd_we=1, sd_req=1, go WRITE, empty the buffer.
  2. Else ram_rd=1 and (cache invalid or cache_addr != ram_addr) -> sd_addr=ram_addr, sd_we=0, sd_req=1, go READ.
  3. Else stay.
- WRITE: on sd_ack, sd_req=0 and go IDLE.
  - If the cache is valid and cache_addr == sd_addr, cache data <= sd_din (coherency).
- READ: on sd_ack, sd_req=0, cache_addr <= sd_addr, ram_dout <= sd_dout, go IDLE.
  - Cache valid <= 1, unless flush was seen during this transaction; then valid stays 0 and the next IDLE cycle re-issues the read.
- A ram_addr change during READ does not abort the transaction. On return to IDLE the miss check runs again against the new address.
- Watchdog:
  - The counter clears on entry to WRITE/READ and increments each cycle while sd_req=1 without sd_ack.
  - On reaching TIMEOUT: sd_req=0, err=1, go IDLE.
  - On a READ timeout: ram_dout=8'hFF, cache valid=1 for that address (prevents a request storm).
  - An sd_ack arriving in IDLE is ignored.
- flush: cache valid <= 0 on the next edge. Write buffer and in-flight transactions are unaffected.
- ram_ready (combinational from registers):
  - ram_ready = buffer empty AND state != WRITE AND (ram_rd=0 OR (cache valid AND cache_addr == ram_addr AND state==IDLE)).
- Latency:
  - Read miss: sd_req rises 1 cycle after ram_rd/ram_addr is presented.
  - ram_dout and ram_ready are valid the cycle after sd_ack.
  - Read hit: ram_ready in the same cycle, 0 added cycles.
- Simultaneous ram_we and ram_rd miss in IDLE: the write goes first, then the read.
- A write to the cached address updates the cache, so a subsequent read hits without SDRAM access.

Test Plan:
- Reset, then ram_rd=1, addr=0x00100, controller acks after 3 cycles with 0x5A:
  - sd_req high 1 cycle after ram_rd, exactly 1 request issued.
  - ram_dout=0x5A and ram_ready=1 the cycle after ack.
  - Holding the address for 20 cycles issues no further sd_req.
- Stream of 16 ram_we pulses (addr 0..15, data 0xA0+i), controller ack delay 4 cycles, upstream waiting on ram_ready:
  - 16 write transactions, in order, with matching sd_addr/sd_din.
  - No byte dropped.
- Cached read of 0x200 = 0x11, then write 0x77 to 0x200, then read 0x200:
  - The read returns 0x77 with no SDRAM read issued.
- flush asserted while a READ of 0x300 is in flight:
  - After ack, ram_ready stays 0 and a second read of 0x300 is issued.
  - ram_ready goes high after the second ack.
- Controller never acks, TIMEOUT=8, read 0x400:
  - sd_req drops after 8 cycles, err=1, ram_dout=0xFF, ram_ready=1.
  - The stale ack that arrives afterwards is ignored.
- reset_n pulsed low mid-WRITE:
  - sd_req=0 asynchronously, buffer empty, err=0, ram_dout=0xFF.
  - A following ack has no effect.
